// File: rtl/hist_eq_lut_builder.sv
// Builds a 256-entry histogram-equalization LUT from the cumulative histogram via a CDF read port,
// then remaps a streaming pixel input through the finished table.
module hist_eq_lut_builder #(
  parameter int unsigned ImageSize = 640 * 480,
  localparam int unsigned CW = $clog2(ImageSize + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_start,
  output logic [7:0]    o_cdf_addr,
  input  logic [CW-1:0] i_cdf_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_lut_ready,
  input  logic [7:0]    i_pixel_data,
  input  logic          i_pixel_valid,
  output logic [7:0]    o_pixel_data,
  output logic          o_pixel_valid
);

  localparam int unsigned NW = CW + 8;

  typedef enum logic [1:0] {StIdle, StScan, StBuild, StDone} state_e;

  state_e state_q, state_d;

  logic [8:0]    scan_cnt_q;
  logic [3:0]    slot_q;
  logic [7:0]    addr_q;
  logic [CW-1:0] cdf_min_q;
  logic          min_found_q;
  logic [NW-1:0] rem_q;
  logic [NW-1:0] den_sh_q;
  logic          den_zero_q;
  logic [6:0]    quot_q;
  logic          lut_ready_q;
  logic [7:0]    lut_q [256];

  logic          scan_last;
  logic          slot_last;
  logic          level_last;
  logic [CW-1:0] cdf_diff;
  logic [NW-1:0] num_d;
  logic [CW-1:0] den_d;
  logic          rem_ge;
  logic [NW-1:0] rem_step;
  logic [7:0]    quot_step;
  logic [7:0]    lut_wdata;
  logic          lut_we;

  assign scan_last  = (scan_cnt_q == 9'd256);
  assign slot_last  = (slot_q == 4'd9);
  assign level_last = (addr_q == 8'hff);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_start) state_d = StScan;
      StScan:  if (scan_last) state_d = StBuild;
      StBuild: if (slot_last && level_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Numerator/denominator for the level whose CDF value is on i_cdf_data (slot cycle 1).
  always_comb begin
    cdf_diff = i_cdf_data - cdf_min_q;
    num_d    = '0;
    if (i_cdf_data > cdf_min_q) begin
      num_d = ({8'd0, cdf_diff} << 8) - {8'd0, cdf_diff};
    end
    den_d = CW'(ImageSize) - cdf_min_q;
  end

  // One restoring-division step; if num >= 256*den every step subtracts, so the
  // quotient naturally saturates at 255.
  always_comb begin
    rem_ge    = (rem_q >= den_sh_q);
    rem_step  = rem_ge ? (rem_q - den_sh_q) : rem_q;
    quot_step = {quot_q, rem_ge};
    lut_wdata = den_zero_q ? addr_q : quot_step;
    lut_we    = (state_q == StBuild) && slot_last;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      scan_cnt_q  <= '0;
      slot_q      <= '0;
      addr_q      <= '0;
      cdf_min_q   <= '0;
      min_found_q <= 1'b0;
      rem_q       <= '0;
      den_sh_q    <= '0;
      den_zero_q  <= 1'b0;
      quot_q      <= '0;
      lut_ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            scan_cnt_q  <= '0;
            addr_q      <= '0;
            cdf_min_q   <= '0;
            min_found_q <= 1'b0;
            lut_ready_q <= 1'b0;
          end
        end
        StScan: begin
          scan_cnt_q <= scan_cnt_q + 9'd1;
          if (scan_cnt_q < 9'd255) begin
            addr_q <= scan_cnt_q[7:0] + 8'd1;
          end
          // Data on the port lags the address by one cycle, so count 0 carries nothing.
          if (scan_cnt_q != 9'd0 && !min_found_q && i_cdf_data != '0) begin
            cdf_min_q   <= i_cdf_data;
            min_found_q <= 1'b1;
          end
          if (scan_last) begin
            addr_q <= '0;
            slot_q <= '0;
          end
        end
        StBuild: begin
          slot_q <= slot_q + 4'd1;
          if (slot_q == 4'd1) begin
            rem_q      <= num_d;
            den_sh_q   <= NW'({den_d, 7'd0});
            den_zero_q <= (den_d == '0);
            quot_q     <= '0;
          end else if (slot_q >= 4'd2) begin
            rem_q    <= rem_step;
            den_sh_q <= den_sh_q >> 1;
            quot_q   <= quot_step[6:0];
          end
          if (slot_last) begin
            slot_q <= '0;
            addr_q <= addr_q + 8'd1;
            if (level_last) begin
              lut_ready_q <= 1'b1;
            end
          end
        end
        StDone: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Table storage has no reset; stale contents are masked by lut_ready_q.
  always_ff @(posedge i_clk) begin
    if (lut_we) begin
      lut_q[addr_q] <= lut_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pixel_valid <= 1'b0;
      o_pixel_data  <= '0;
    end else begin
      o_pixel_valid <= i_pixel_valid;
      if (i_pixel_valid) begin
        o_pixel_data <= lut_ready_q ? lut_q[i_pixel_data] : i_pixel_data;
      end
    end
  end

  assign o_cdf_addr  = addr_q;
  assign o_busy      = (state_q == StScan) || (state_q == StBuild);
  assign o_done      = (state_q == StDone);
  assign o_lut_ready = lut_ready_q;

endmodule

// File: tb/tb_hist_eq_lut_builder.sv
// Self-checking bench for hist_eq_lut_builder: CDF source model, reference LUT computed
// arithmetically, and a pixel scoreboard drained by an independent monitor.
module tb_hist_eq_lut_builder;

  localparam int unsigned IMG = 256;
  localparam int unsigned CW  = $clog2(IMG + 1);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [7:0]    cdf_addr;
  logic [CW-1:0] cdf_data;
  logic          busy;
  logic          done;
  logic          lut_ready;
  logic [7:0]    pix_in;
  logic          pix_in_valid;
  logic [7:0]    pix_out;
  logic          pix_out_valid;

  int errors = 0;
  int checks = 0;
  int cdf_mem   [256];
  int model_lut [256];
  bit model_ready = 0;
  int exp_q [$];

  hist_eq_lut_builder #(
    .ImageSize(IMG)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_start      (start),
    .o_cdf_addr   (cdf_addr),
    .i_cdf_data   (cdf_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_lut_ready  (lut_ready),
    .i_pixel_data (pix_in),
    .i_pixel_valid(pix_in_valid),
    .o_pixel_data (pix_out),
    .o_pixel_valid(pix_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered CDF memory: one cycle of read latency.
  always @(posedge clk) cdf_data <= CW'(cdf_mem[cdf_addr]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference table straight from the equalization formula.
  function automatic void build_model();
    int mn = 0;
    bit found = 0;
    longint num, den, q;
    for (int l = 0; l < 256; l++) begin
      if (!found && cdf_mem[l] != 0) begin
        mn = cdf_mem[l];
        found = 1;
      end
    end
    den = longint'(IMG) - mn;
    for (int l = 0; l < 256; l++) begin
      if (den == 0) begin
        model_lut[l] = l;
      end else begin
        num = (cdf_mem[l] > mn) ? longint'(cdf_mem[l] - mn) * 255 : 0;
        q = num / den;
        model_lut[l] = (q > 255) ? 255 : int'(q);
      end
    end
  endfunction

  function automatic int expect_pix(input int p);
    return model_ready ? model_lut[p] : p;
  endfunction

  task automatic send_pix(input int p);
    pix_in       = 8'(p);
    pix_in_valid = 1'b1;
    exp_q.push_back(expect_pix(p));
    tick();
    pix_in_valid = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pix_out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 32'(pix_out), 32'hffff_ffff);
        end else begin
          chk("pixel", 32'(pix_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Start a build (optionally with a pixel in the start cycle) and time it to o_done.
  task automatic run_build(input bit restart, input bit with_pix, input int pix);
    int cyc;
    int busy_cnt;
    start = 1'b1;
    if (with_pix) begin
      pix_in       = 8'(pix);
      pix_in_valid = 1'b1;
      exp_q.push_back(expect_pix(pix));
    end
    tick();
    start        = 1'b0;
    pix_in_valid = 1'b0;
    model_ready  = 0;
    build_model();
    cyc      = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      if (busy === 1'b1) busy_cnt++;
      if (restart && cyc == 500) start = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        pix_in       = 8'($urandom_range(0, 255));
        pix_in_valid = 1'b1;
        exp_q.push_back(expect_pix(int'(pix_in)));
      end
      tick();
      start        = 1'b0;
      pix_in_valid = 1'b0;
      cyc++;
    end
    chk("done_cycle", 32'(cyc), 32'd2818);
    chk("busy_cycles", 32'(busy_cnt), 32'd2817);
    chk("lut_ready_at_done", 32'(lut_ready), 32'd1);
    model_ready = 1;
    send_pix(int'($urandom_range(0, 255)));
    chk("done_single_pulse", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int acc;
    rst_n        = 1'b0;
    start        = 1'b0;
    pix_in       = '0;
    pix_in_valid = 1'b0;
    for (int l = 0; l < 256; l++) cdf_mem[l] = 0;
    tick();
    tick();
    chk("rst_cdf_addr", 32'(cdf_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_lut_ready", 32'(lut_ready), 32'd0);
    chk("rst_pix_valid", 32'(pix_out_valid), 32'd0);
    chk("rst_pix_data", 32'(pix_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // Pass-through before any table exists.
    send_pix(37);
    chk("passthru_lut_ready", 32'(lut_ready), 32'd0);
    for (int i = 0; i < 20; i++) send_pix(int'($urandom_range(0, 255)));

    // Two-step CDF: cdf_min = 128, den = 128.
    for (int l = 0; l < 256; l++) cdf_mem[l] = (l < 100) ? 0 : (l < 200) ? 128 : 256;
    run_build(1'b0, 1'b0, 0);
    send_pix(50);
    send_pix(100);
    send_pix(150);
    send_pix(200);
    send_pix(255);

    // Degenerate CDF (den = 0); start shares its cycle with a pixel remapped by the old table.
    for (int l = 0; l < 256; l++) cdf_mem[l] = (l < 10) ? 0 : 256;
    run_build(1'b0, 1'b1, 150);
    send_pix(37);
    send_pix(200);

    // Linear CDF with an ignored restart pulse mid-build.
    for (int l = 0; l < 256; l++) cdf_mem[l] = l + 1;
    run_build(1'b1, 1'b0, 0);
    send_pix(0);
    send_pix(128);
    send_pix(255);

    // Random monotonic CDF with leading zeros.
    acc = 0;
    for (int l = 0; l < 256; l++) begin
      if (l >= 20) acc += int'($urandom_range(0, 3));
      cdf_mem[l] = (acc > int'(IMG)) ? int'(IMG) : acc;
    end
    cdf_mem[255] = IMG;
    run_build(1'b0, 1'b0, 0);
    for (int i = 0; i < 40; i++) send_pix(int'($urandom_range(0, 255)));

    // Reset at cycle 1000 of a build.
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 1000; c++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_lut_ready", 32'(lut_ready), 32'd0);
    chk("midrst_cdf_addr", 32'(cdf_addr), 32'd0);
    chk("midrst_pix_valid", 32'(pix_out_valid), 32'd0);
    chk("midrst_pix_data", 32'(pix_out), 32'd0);
    model_ready = 0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (done === 1'b1) chk("no_done_after_reset", 32'(done), 32'd0);
      tick();
    end
    chk("idle_after_reset", 32'(busy), 32'd0);
    send_pix(90);
    tick();
    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hist_eq_lut_builder.md
# hist_eq_lut_builder

Reads the 256-entry cumulative histogram (CDF) produced by the histogram-equalization front end and builds the 256 × 8-bit equalization look-up table. Once the table is built, it remaps a streaming pixel input through it. It sits downstream of the cumulative-histogram calculator: the calculator writes the CDF, and this block is its reader. It drives the CDF read port, runs a sequential divider per grey level, and applies the resulting table to the next frame.

## Interface
- imageSize, 640*480, pixels per frame; CDF width CW = $clog2(imageSize+1).
- i_clk  in  1  clock; all logic on rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  single-cycle request to build the table from the current CDF.
- o_cdf_addr  out  8  CDF read address (grey level).
- i_cdf_data  in  CW  CDF value for the address presented in the previous cycle (registered source, 1-cycle latency).
- o_busy  out  1  high while scanning or building.
- o_done  out  1  one-cycle pulse when the table is complete.
- o_lut_ready  out  1  high while a valid built table is being applied.
- i_pixel_data  in  8  input pixel.
- i_pixel_valid  in  1  input pixel qualifier.
- o_pixel_data  out  8  remapped pixel.
- o_pixel_valid  out  1  output pixel qualifier.

## Operation
- States are IDLE, SCAN, BUILD and DONE.
- IDLE → SCAN: when i_start is sampled high. At the same time, o_lut_ready clears and o_busy sets.
- i_start is ignored in SCAN, BUILD and DONE.
- SCAN:
  - Sweep o_cdf_addr from 0 to 255.
  - Capture cdf_min as the first nonzero i_cdf_data returned.
  - If every entry is 0, cdf_min = 0.
- BUILD, for each level L = 0..255, in order:
  - Fetch CDF[L].
  - num = (CDF[L] > cdf_min) ? (CDF[L] − cdf_min) × 255 : 0, width CW+8.
  - den = imageSize − cdf_min.
  - LUT[L] = floor(num / den), computed by an 8-step restoring divider producing the quotient MSB first.
  - Quotient is ≤ 255 by construction; it saturates at 255 regardless.
  - If den == 0, LUT[L] = L (identity); the divider is skipped but slot timing is unchanged.
- DONE:
  - Single cycle: o_done = 1, o_lut_ready sets, o_busy clears.
  - Then → IDLE.
- Pixel path (every state):
  - o_pixel_valid follows i_pixel_valid with one cycle of delay.
  - If o_lut_ready = 1, o_pixel_data = LUT[i_pixel_data]; otherwise o_pixel_data = i_pixel_data (pass-through).
  - The ready/pass-through choice is made in the cycle the pixel is sampled.
- The LUT is register storage written in place; it is never read as "ready" while partially built.

## Timing
- Reset values:
  - State = IDLE.
  - o_cdf_addr = 0.
  - o_busy, o_done, o_lut_ready, o_pixel_valid = 0.
  - o_pixel_data = 0.
  - cdf_min = 0.
  - LUT contents undefined; masked by o_lut_ready = 0.
- Let i_start be sampled at edge 0.
- SCAN occupies cycles 1..257:
  - Address a is presented in cycle a+1.
  - Its data is consumed in cycle a+2.
- BUILD occupies cycles 258..2817, with a 10-cycle slot per level. Within the slot for level L:
  - Slot cycle 0: present address L.
  - Slot cycle 1: latch data and form num/den.
  - Slot cycles 2..9: divide steps; LUT[L] is written at the edge ending slot cycle 9.
- o_done = 1 in cycle 2818 only. o_lut_ready is 1 from cycle 2818 onward.
- Pixel latency is exactly 1 cycle, with no back-pressure. A pixel accepted in cycle 2818 is remapped.
- Reset asserted mid-SCAN or mid-BUILD: immediate return to reset values. A new i_start is required.
- Simultaneous i_start and i_pixel_valid in IDLE with o_lut_ready = 1: that pixel is still remapped, because o_lut_ready clears at the same edge.

## Test plan
- Pass-through before any build: after reset, drive pixel 37 with i_pixel_valid=1 → next cycle o_pixel_data=37, o_pixel_valid=1, o_lut_ready=0.
- Degenerate image: imageSize=16, CDF[L]=0 for L<10 and 16 for L≥10 (den=0) → o_done in cycle 2818 after i_start; then pixel 37 → 37 and pixel 200 → 200.
- Two-step CDF: imageSize=16, CDF=0 for L<100, 8 for 100..199, 16 for ≥200 (cdf_min=8, den=8) → pixels 50→0, 100→0, 150→0, 200→255, 255→255.
- Linear CDF: imageSize=256, CDF[L]=L+1 (cdf_min=1, den=255) → LUT[L]=L; pixel 0→0, pixel 128→128, pixel 255→255; o_busy high for exactly 2817 cycles.
- Reset mid-build: assert i_reset_n=0 at cycle 1000 after i_start → all outputs 0 and no o_done. After release, pixel 90 passes through as 90.
- Ignored restart: pulse i_start again at cycle 500 while busy → o_done still occurs exactly once, at cycle 2818 relative to the first i_start.
